cntr_change_fifo: RTL
=====================

# cntr_change_fifo

Downstream monitor stage for the 8-bit load/increment counter. It samples the counter output `q` every clock and detects each change of value. Each new value is pushed, tagged with a wrap-around flag, into a small FIFO. The FIFO drains over a valid/ready handshake to a scoreboard or logger, so every counter transition is captured in order without the consumer sampling every cycle.

## Interface

Parameters:
- `WIDTH`, 8, width of the counter value and of `out_data`.
- `DEPTH`, 4, FIFO entries; must be a power of two, ≥2.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `q`  in  WIDTH  counter output under observation.
- `out_data`  out  WIDTH  head-of-FIFO counter value.
- `out_wrap`  out  1  head entry was a wrap from all-ones to 0.
- `out_valid`  out  1  head entry present.
- `out_ready`  in  1  consumer accepts head entry.
- `count`  out  $clog2(DEPTH+1)  current number of stored entries.
- `overflow`  out  1  sticky; an event was dropped because the FIFO was full.

## Operation

- Internal state:
  - `q_prev` (WIDTH)
  - `primed` (1)
  - FIFO storage of DEPTH × (WIDTH+1)
  - read/write pointers and occupancy
  - `overflow`
- Priming:
  - The first rising edge with `rst`=0 loads `q_prev`←`q` and sets `primed`=1.
  - No event is generated on that edge.
- Event: on an edge where `primed`=1 and `q != q_prev`.
  - Entry = {wrap, `q`}.
  - wrap=1 only when `q_prev` == all-ones and `q` == 0; any other change, including a load of 0, gives wrap=0.
- `q_prev`←`q` on every non-reset edge.
- An unchanged value generates no event. This includes a load of the current value and `inc`=0.
- Push: accepted when `count` < DEPTH, or when `count` == DEPTH and a pop occurs on the same edge.
- Drop:
  - When the FIFO is full and no pop occurs, the event is discarded and `overflow` is set to 1.
  - Stored entries are never overwritten.
  - `overflow` is cleared only by `rst`.
- Pop: occurs on an edge with `out_valid`=1 and `out_ready`=1.
  - `out_ready` while `out_valid`=0 has no effect.
- Push and pop on the same edge: both take effect and `count` is unchanged. This holds when full and when at 1 entry.
- Outputs:
  - `out_data`/`out_wrap` present the head entry.
  - Both are forced to 0 while empty.
  - The head is stable while `out_valid`=1 and `out_ready`=0.
- Pointers wrap modulo DEPTH. `count` saturates at DEPTH by construction and never exceeds it.

## Timing

- Reset: on an edge with `rst`=1, all of the following take effect, and any stored entries are discarded:
  - `out_valid`=0, `out_data`=0, `out_wrap`=0, `count`=0, `overflow`=0
  - `primed`=0, `q_prev`=0
- Reset asserted mid-operation has the same effect. A change of `q` on the first edge after reset is not reported because of priming.
- Latency:
  - A value of `q` first sampled differing at edge k is stored at edge k.
  - `out_valid`=1 and `count` is incremented in the cycle after edge k.
  - The consumer may pop at edge k+1 at the earliest.
- Throughput: one push and one pop per cycle sustained. A counter incrementing every cycle with `out_ready`=1 never fills the FIFO.
- `overflow` rises in the cycle after the dropping edge.
- All outputs are registered or decoded from registered state only, with no combinational path from `q` or `out_ready`.

## Test plan

1. Assert `rst` for 2 cycles, hold `q`=0x05 for 10 cycles with `out_ready`=1 → `out_valid`=0, `count`=0 throughout (priming only).
2. After priming at 0x10, step `q` 0x11, 0x12, 0x13 on consecutive edges with `out_ready`=1 → entries 0x11, 0x12, 0x13 with wrap=0, each valid one cycle after its sampling edge, `count` ≤1.
3. Step `q` 0xFE→0xFF→0x00, then load 0x00→0x07→0x00 → entries {0,FF}, {1,00}, {0,07}, {0,00}. Only the all-ones-to-zero step sets wrap.
4. `out_ready`=0, five changes 0x01..0x05 → `count`=4, `overflow`=1 after the fifth edge. Drain yields 0x01..0x04 in order, then `out_valid`=0 with `out_data`=0.
5. FIFO full with `out_ready`=1 while `q` changes 0x20→0x21 → head popped and 0x21 pushed on the same edge, `count` stays 4, `overflow` unchanged at 0.
6. Three entries stored with `overflow`=1, pulse `rst` one cycle → next cycle `out_valid`=0, `count`=0, `overflow`=0. A `q` change on the first post-reset edge produces no entry, and the following change does produce one.

Source files
------------

// File: rtl/cntr_change_fifo.sv
// Change monitor for the load/increment counter: every new value of q is queued
// with a wrap flag and drained to a consumer over a valid/ready handshake.
module cntr_change_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           q,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_wrap,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] q_prev;
  logic             primed;
  logic [WIDTH:0]   mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  logic change;
  logic wrap;
  logic pop;
  logic push;
  logic drop;

  // Edge detect against the previous sample; the pop frees a slot for a same-edge push
  always_comb begin
    change = primed && (q != q_prev);
    wrap   = (q_prev == '1) && (q == '0);
    pop    = out_valid && out_ready;
    push   = change && ((count != FULL_CNT) || pop);
    drop   = change && (count == FULL_CNT) && !pop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_prev   <= '0;
      primed   <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      q_prev <= q;
      primed <= 1'b1;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
      if (drop) overflow <= 1'b1;
    end
  end

  // Storage carries no reset; emptiness masks stale contents at the output
  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= {wrap, q};
  end

  assign out_valid = (count != '0);
  assign out_data  = out_valid ? mem[rd_ptr][WIDTH-1:0] : '0;
  assign out_wrap  = out_valid ? mem[rd_ptr][WIDTH] : 1'b0;

endmodule
